// File: rtl/pc_fetch.sv
// pc_fetch: holds the PC, fetches one instruction at a time over req/gnt/rvalid and computes the next PC on retire.
// Optional ALIGN_CHECK_EN: a misaligned jr redirects to EXC_VECTOR and sets the sticky misalign_err.
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef ALIGN_CHECK_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic [2:0]  pc_next_c,
  input  logic [31:0] br_offset,
  input  logic [31:0] jr_target
`ifdef ALIGN_CHECK_EN
  , output logic      misalign_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_capture;
  logic        w_retire;
`ifdef ALIGN_CHECK_EN
  logic        r_misalign_err;
  logic        w_misalign;
`endif

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_retire   = (r_state == S_VALID) && retire;

  // rvalid is only honoured in the grant cycle of REQ or in WAIT; anything else is a stale beat.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_VALID;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (retire) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next-PC select, priority jr > j > branch > sequential.
  always_comb begin
    w_pc_next = w_pc_plus4;
`ifdef ALIGN_CHECK_EN
    w_misalign = 1'b0;
`endif
    if (pc_next_c[2]) begin
      w_pc_next = jr_target;
`ifdef ALIGN_CHECK_EN
      if (jr_target[1:0] != 2'b00) begin
        w_pc_next  = EXC_VECTOR;
        w_misalign = 1'b1;
      end
`endif
    end else if (pc_next_c[1]) begin
      w_pc_next = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (pc_next_c[0]) begin
      w_pc_next = w_pc_plus4 + (br_offset << 2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
`ifdef ALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_instr <= imem_rdata;
      if (w_retire)  r_pc    <= w_pc_next;
`ifdef ALIGN_CHECK_EN
      if (w_retire && w_misalign) r_misalign_err <= 1'b1;
`endif
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_VALID);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
`ifdef ALIGN_CHECK_EN
  assign misalign_err = r_misalign_err;
`endif

endmodule
